// File: rtl/twiddle_gen.sv
// twiddle_gen: k -> (tw_re, tw_im) twiddle from a quarter-wave cos table; in (in_valid/in_ready, in_k, in_inv) -> out (out_valid/out_ready, tw_re, tw_im)
module twiddle_gen #(
  parameter int    N_FFT     = 1024,
  parameter int    TW_W      = 16,
  parameter string INIT_FILE = "twcos.hex"
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [$clog2(N_FFT)-1:0]  in_k,
  input  logic                      in_inv,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [TW_W:0]      tw_re,
  output logic signed [TW_W:0]      tw_im
);
  localparam int ADDR_W = $clog2(N_FFT);
  localparam int Q = N_FFT / 4;
  localparam int AW = ADDR_W - 2;
  localparam logic [AW:0] QV = {1'b1, {AW{1'b0}}};
  function automatic logic [Q*TW_W-1:0] build_rom();
    logic [Q*TW_W-1:0] t;
    longint x, x2, term, sum;
    t = '0;
    for (int i = 0; i < Q; i++) begin
      x = (64'sd6746518852 * i + N_FFT / 2) / N_FFT;
      x2 = (x * x) >>> 30;
      term = 64'sd1 <<< 30;
      sum = term;
      for (int n = 1; n <= 12; n++) begin
        term = -((term * x2) >>> 30) / (2 * n - 1) / (2 * n);
        sum = sum + term;
      end
      t[i*TW_W +: TW_W] = TW_W'((sum * (64'sd1 <<< (TW_W - 1)) + (64'sd1 <<< 29)) >>> 30);
    end
    return t;
  endfunction
  localparam logic [Q*TW_W-1:0] ROM = build_rom();
  if (INIT_FILE == "") begin : g_no_file
  end
  logic stall;
  logic v1_q, v1_d, inv1_q, inv1_d, v2_q, v2_d, inv2_q, inv2_d, ov_q, ov_d;
  logic [1:0] q1_q, q1_d, q2_q, q2_d;
  logic [AW-1:0] a1_q, a1_d;
  logic [AW:0] b1_q, b1_d;
  logic [TW_W-1:0] ma_q, ma_d, mb_q, mb_d;
  logic [TW_W:0] ea, eb, cos_v, sin_v;
  logic signed [TW_W:0] re_q, re_d, im_q, im_d;
  assign stall = ov_q && !out_ready;
  assign in_ready = !stall;
  assign out_valid = ov_q;
  assign tw_re = re_q;
  assign tw_im = im_q;
  always_comb begin
    v1_d = in_valid;
    q1_d = in_k[ADDR_W-1 -: 2];
    a1_d = in_k[AW-1:0];
    b1_d = QV - {1'b0, in_k[AW-1:0]};
    inv1_d = in_inv;
    v2_d = v1_q;
    q2_d = q1_q;
    inv2_d = inv1_q;
    ma_d = ROM[int'(a1_q)*TW_W +: TW_W];
    mb_d = (b1_q == QV) ? '0 : ROM[int'(b1_q[AW-1:0])*TW_W +: TW_W];
    ea = {1'b0, ma_q};
    eb = {1'b0, mb_q};
    cos_v = (q2_q == 2'd0) ? ea : (q2_q == 2'd1) ? -eb : (q2_q == 2'd2) ? -ea : eb;
    sin_v = (q2_q == 2'd0) ? eb : (q2_q == 2'd1) ? ea : (q2_q == 2'd2) ? -eb : -ea;
    re_d = v2_q ? cos_v : re_q;
    im_d = v2_q ? (inv2_q ? sin_v : -sin_v) : im_q;
    ov_d = v2_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      inv1_q <= 1'b0;
      q1_q <= '0;
      a1_q <= '0;
      b1_q <= '0;
      v2_q <= 1'b0;
      inv2_q <= 1'b0;
      q2_q <= '0;
      ma_q <= '0;
      mb_q <= '0;
      ov_q <= 1'b0;
      re_q <= '0;
      im_q <= '0;
    end else if (!stall) begin
      v1_q <= v1_d;
      inv1_q <= inv1_d;
      q1_q <= q1_d;
      a1_q <= a1_d;
      b1_q <= b1_d;
      v2_q <= v2_d;
      inv2_q <= inv2_d;
      q2_q <= q2_d;
      ma_q <= ma_d;
      mb_q <= mb_d;
      ov_q <= ov_d;
      re_q <= re_d;
      im_q <= im_d;
    end
  end
endmodule

// File: tb/tb_twiddle_gen.sv
// tb_twiddle_gen: directed and swept checks of twiddle_gen at 1024/16 and 64/12
module tb_twiddle_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_inv = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid;
  logic [9:0] in_k = '0;
  logic signed [16:0] tw_re, tw_im;
  logic v64 = 1'b0, inv64 = 1'b0, ordy64 = 1'b1;
  logic r64, ov64;
  logic [5:0] k64 = '0;
  logic signed [12:0] re64, im64;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  twiddle_gen dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_k(in_k), .in_inv(in_inv),
    .out_valid(out_valid), .out_ready(out_ready), .tw_re(tw_re), .tw_im(tw_im)
  );
  twiddle_gen #(.N_FFT(64), .TW_W(12), .INIT_FILE("twcos64.hex")) dut64 (
    .clk(clk), .rst(rst), .in_valid(v64), .in_ready(r64), .in_k(k64), .in_inv(inv64),
    .out_valid(ov64), .out_ready(ordy64), .tw_re(re64), .tw_im(im64)
  );
  function automatic int rnd(real x);
    return x >= 0.0 ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction
  function automatic void ref_tw(input int k, input bit inv, output int re, output int im);
    real a;
    a = 6.283185307179586 * k / 1024.0;
    re = rnd(32768.0 * $cos(a));
    im = inv ? rnd(32768.0 * $sin(a)) : -rnd(32768.0 * $sin(a));
  endfunction
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++;
    if (tw_re !== 17'sd0 || tw_im !== 17'sd0) begin bad++; $display("FAIL reset_tw: got (%0d,%0d) want (0,0)", tw_re, tw_im); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++;
    if (ov64 !== 1'b0 || r64 !== 1'b1) begin bad++; $display("FAIL reset_dut64: got v=%b rdy=%b want v=0 rdy=1", ov64, r64); end
  endtask
  task automatic test_directed();
    int ks[8] = '{0, 256, 512, 768, 1, 128, 255, 1};
    bit iv[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    int er[8] = '{32768, 0, -32768, 0, 32767, 23170, 201, 32767};
    int ei[8] = '{0, -32768, 0, 32768, -201, -23170, -32767, 201};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      in_valid = i < 8;
      in_k = i < 8 ? 10'(ks[i]) : 10'd0;
      in_inv = i < 8 ? iv[i] : 1'b0;
      out_ready = 1'b1;
      #1;
      total++;
      if (i >= 3 && i < 11) begin
        if (out_valid !== 1'b1 || tw_re !== 17'(er[i-3]) || tw_im !== 17'(ei[i-3])) begin
          bad++;
          $display("FAIL directed k=%0d inv=%0d: got v=%b (%0d,%0d) want v=1 (%0d,%0d)",
                   ks[i-3], iv[i-3], out_valid, tw_re, tw_im, er[i-3], ei[i-3]);
        end
      end else if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL directed_idle cycle %0d: got out_valid=%b want 0", i, out_valid);
      end
    end
  endtask
  task automatic test_small();
    int ks[3] = '{16, 8, 63};
    int er[3] = '{0, 1448, 2038};
    int ei[3] = '{-2048, -1448, 201};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      v64 = i < 3;
      k64 = i < 3 ? 6'(ks[i]) : 6'd0;
      inv64 = 1'b0;
      #1;
      total++;
      if (i >= 3 && i < 6) begin
        if (ov64 !== 1'b1 || re64 !== 13'(er[i-3]) || im64 !== 13'(ei[i-3])) begin
          bad++;
          $display("FAIL small k=%0d: got v=%b (%0d,%0d) want v=1 (%0d,%0d)",
                   ks[i-3], ov64, re64, im64, er[i-3], ei[i-3]);
        end
      end else if (ov64 !== 1'b0) begin
        bad++;
        $display("FAIL small_idle cycle %0d: got out_valid=%b want 0", i, ov64);
      end
    end
  endtask
  task automatic test_sweep(input bit inv);
    int qre[$], qim[$], qk[$];
    int sent = 0, got = 0, cyc = 0, re, im, ek;
    bit acc = 1'b0;
    in_inv = inv;
    in_valid = 1'b0;
    while (got < 1024 && cyc < 10000) begin
      @(negedge clk);
      cyc++;
      if (acc) in_valid = 1'b0;
      if (!in_valid && sent < 1024 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_k = 10'(sent);
      end
      out_ready = $urandom_range(0, 4) != 0;
      #1;
      acc = in_valid && in_ready;
      if (acc) begin
        ref_tw(sent, inv, re, im);
        qre.push_back(re);
        qim.push_back(im);
        qk.push_back(sent);
        sent++;
      end
      if (out_valid && out_ready) begin
        total++;
        got++;
        if (qk.size() == 0) begin
          bad++;
          $display("FAIL sweep_extra inv=%0d: got (%0d,%0d) want no output", inv, tw_re, tw_im);
        end else begin
          re = qre.pop_front();
          im = qim.pop_front();
          ek = qk.pop_front();
          if (tw_re !== 17'(re) || tw_im !== 17'(im)) begin
            bad++;
            $display("FAIL sweep k=%0d inv=%0d: got (%0d,%0d) want (%0d,%0d)", ek, inv, tw_re, tw_im, re, im);
          end
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    total++;
    if (got != 1024) begin bad++; $display("FAIL sweep_count inv=%0d: got %0d want 1024", inv, got); end
    repeat (4) @(negedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL sweep_drain inv=%0d: got out_valid=%b want 0", inv, out_valid); end
  endtask
  task automatic test_backpressure();
    int qre[$], qim[$];
    int sent = 0, got = 0, cyc = 0, stalls = 0, re, im;
    bit acc = 1'b0, prev_stall = 1'b0;
    logic signed [16:0] pre = '0, pim = '0;
    in_inv = 1'b0;
    in_valid = 1'b0;
    while (got < 16 && cyc < 200) begin
      @(negedge clk);
      if (acc) in_valid = 1'b0;
      if (!in_valid && sent < 16) begin
        in_valid = 1'b1;
        in_k = 10'(sent);
      end
      out_ready = !(cyc >= 6 && cyc < 11);
      cyc++;
      #1;
      acc = in_valid && in_ready;
      if (acc) begin
        ref_tw(sent, 1'b0, re, im);
        qre.push_back(re);
        qim.push_back(im);
        sent++;
      end
      if (prev_stall) begin
        total++;
        if (out_valid !== 1'b1 || tw_re !== pre || tw_im !== pim) begin
          bad++;
          $display("FAIL bp_frozen: got v=%b (%0d,%0d) want v=1 (%0d,%0d)", out_valid, tw_re, tw_im, pre, pim);
        end
      end
      if (out_valid && !out_ready) begin
        stalls++;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
      end
      if (out_valid && out_ready) begin
        total++;
        got++;
        re = qre.size() ? qre.pop_front() : 99999;
        im = qim.size() ? qim.pop_front() : 99999;
        if (tw_re !== 17'(re) || tw_im !== 17'(im)) begin
          bad++;
          $display("FAIL bp_seq item %0d: got (%0d,%0d) want (%0d,%0d)", got - 1, tw_re, tw_im, re, im);
        end
      end
      prev_stall = out_valid && !out_ready;
      pre = tw_re;
      pim = tw_im;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    total++;
    if (got != 16) begin bad++; $display("FAIL bp_count: got %0d want 16", got); end
    total++;
    if (stalls != 5) begin bad++; $display("FAIL bp_stall_cycles: got %0d want 5", stalls); end
  endtask
  task automatic test_reset_midflight();
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      in_valid = i < 3 || i == 9;
      in_k = i == 9 ? 10'd256 : 10'(i + 1);
      in_inv = 1'b0;
      out_ready = 1'b1;
      rst = i == 3;
      #1;
      if (i == 3) begin
        total++;
        if (out_valid !== 1'b1 || tw_re !== 17'sd32767 || tw_im !== -17'sd201) begin
          bad++;
          $display("FAIL rst_pre: got v=%b (%0d,%0d) want v=1 (32767,-201)", out_valid, tw_re, tw_im);
        end
      end
      if (i == 4) begin
        total++;
        if (tw_re !== 17'sd0 || tw_im !== 17'sd0) begin bad++; $display("FAIL rst_clear: got (%0d,%0d) want (0,0)", tw_re, tw_im); end
      end
      if (i >= 4 && i < 12) begin
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_stale cycle %0d: got out_valid=%b want 0", i, out_valid); end
      end
      if (i == 9) begin
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", in_ready); end
      end
      if (i == 12) begin
        total++;
        if (out_valid !== 1'b1 || tw_re !== 17'sd0 || tw_im !== -17'sd32768) begin
          bad++;
          $display("FAIL rst_post: got v=%b (%0d,%0d) want v=1 (0,-32768)", out_valid, tw_re, tw_im);
        end
      end
    end
    in_valid = 1'b0;
  endtask
  initial begin
    test_reset();
    test_directed();
    test_small();
    test_sweep(1'b0);
    test_sweep(1'b1);
    test_backpressure();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
